// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-boxes substitute a 128-bit state in 16/LANES beats.
// Optional feature macro INV_SBOX_EN adds inverse tables, selected per state by in_inv.

module sbox (
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [7:0] sub_o
);
  // Forward AES S-box, row-major, entry 0x00 is the leftmost byte
  localparam logic [0:2047] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign sub_o = TABLE[{row_i, col_i, 3'b000} +: 8];
endmodule

`ifdef INV_SBOX_EN
module inv_sbox (
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [7:0] sub_o
);
  localparam logic [0:2047] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign sub_o = TABLE[{row_i, col_i, 3'b000} +: 8];
endmodule
`endif

module sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);
  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] beat_q;
  logic [CW-1:0] beat_d;
  logic [0:127]  src_q;
  logic [0:127]  res_q;
  logic          idle_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          accept;
  logic [7:0]    sub_b [LANES];
  logic [3:0]    idx   [LANES];

`ifdef INV_SBOX_EN
  logic inv_q;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  // In DONE the retiring edge may also accept, so ready follows out_ready there
  assign in_ready  = idle_q | (out_valid_q & out_ready);
  assign accept    = in_valid & in_ready;
  assign beat_d    = beat_q + CW'(1);
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign busy      = busy_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] src_b;
    logic [7:0] fwd_b;

    assign idx[j] = 4'(32'(beat_q) * LANES + 32'(j));
    assign src_b  = src_q[{idx[j], 3'b000} +: 8];

    sbox u_sbox (.row_i(src_b[7:4]), .col_i(src_b[3:0]), .sub_o(fwd_b));
`ifdef INV_SBOX_EN
    logic [7:0] inv_b;
    inv_sbox u_inv_sbox (.row_i(src_b[7:4]), .col_i(src_b[3:0]), .sub_o(inv_b));
    assign sub_b[j] = inv_q ? inv_b : fwd_b;
`else
    assign sub_b[j] = fwd_b;
`endif
  end

  // Control FSM plus source/result datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      src_q       <= '0;
      res_q       <= '0;
      idle_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef INV_SBOX_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q     <= S_BUSY;
            src_q       <= in_data;
            beat_q      <= '0;
            idle_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef INV_SBOX_EN
            inv_q       <= in_inv;
`endif
          end else if (state_q == S_DONE && out_ready) begin
            state_q     <= S_IDLE;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        S_BUSY: begin
          for (int unsigned j = 0; j < LANES; j++) begin
            res_q[{idx[j], 3'b000} +: 8] <= sub_b[j];
          end
          if (beat_q == LAST) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            beat_q <= beat_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: LANES=4 main instance plus LANES=1,2,8,16 instances.

module tb_sub_bytes_iter;
  localparam logic [0:127] VEC_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] SUB_A = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [0:127] VEC_B = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [0:127] SUB_B = 128'hfb13dc2eafb0c3e61c289187b3783447;
`ifdef INV_SBOX_EN
  localparam logic [0:127] INV_B = VEC_A;
`else
  localparam logic [0:127] INV_B = SUB_B;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] out_data;
  logic         busy;

  logic         x_in_valid [4];
  logic         x_in_ready [4];
  logic         x_out_valid[4];
  logic [0:127] x_out_data [4];
  logic         x_busy     [4];
  logic         x_out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sub_bytes_iter #(.LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    sub_bytes_iter #(.LANES(LN)) u_dut_l (
      .clk(clk), .rst(rst), .in_valid(x_in_valid[g]), .in_ready(x_in_ready[g]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(x_out_valid[g]),
      .out_ready(x_out_ready), .out_data(x_out_data[g]), .busy(x_busy[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the accept edge until out_valid, -1 on timeout
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_out_valid: got %b want 0", out_valid); end
    // Reset while a finished result is waiting in DONE
    in_data = VEC_A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_done: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_done_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rst_done_out_data: got %h want 0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_done_in_ready: got %b want 1", in_ready); end
    step();
    rst = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_done_after: got v=%b b=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_forward();
    int lat;
    in_inv = 1'b0; in_data = VEC_A; in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; in_data = '1;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL fwd_busy_flags: got b=%b r=%b v=%b want 1 0 0", busy, in_ready, out_valid); end
    wait_out(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL fwd_latency: got %0d want 4", lat); end
    total++; if (out_data !== SUB_A) begin bad++; $display("FAIL fwd_data: got %h want %h", out_data, SUB_A); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL fwd_retire: got v=%b r=%b b=%b want 0 1 0", out_valid, in_ready, busy); end
  endtask

  task automatic test_inverse();
    int lat;
    in_inv = 1'b1; in_data = VEC_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_inv = 1'b0;
    wait_out(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL inv_latency: got %0d want 4", lat); end
    total++; if (out_data !== INV_B) begin bad++; $display("FAIL inv_data: got %h want %h", out_data, INV_B); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    in_data = VEC_A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0); in_data = VEC_B;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_data !== SUB_A) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1 %h", i, out_valid, out_data, SUB_A); end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_after: got b=%b v=%b r=%b want 0 0 1", busy, out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_data = VEC_A; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_data = VEC_B;
    wait_out(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL b2b_lat1: got %0d want 4", lat); end
    total++; if (out_data !== SUB_A) begin bad++; $display("FAIL b2b_data1: got %h want %h", out_data, SUB_A); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_no_idle: got b=%b v=%b want 1 0", busy, out_valid); end
    wait_out(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL b2b_lat2: got %0d want 4", lat); end
    total++; if (out_data !== SUB_B) begin bad++; $display("FAIL b2b_data2: got %h want %h", out_data, SUB_B); end
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_busy();
    int lat;
    in_data = VEC_A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rstb_abort: got b=%b r=%b v=%b want 0 1 0", busy, in_ready, out_valid); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rstb_quiet[%0d]: got v=%b b=%b want 0 0", i, out_valid, busy); end
    end
    in_data = VEC_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL rstb_latency: got %0d want 4", lat); end
    total++; if (out_data !== SUB_B) begin bad++; $display("FAIL rstb_data: got %h want %h", out_data, SUB_B); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_lanes();
    int lat_exp[4] = '{16, 8, 2, 1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      in_inv = 1'b0; in_data = VEC_A; x_in_valid[i] = 1'b1;
      total++; if (x_in_ready[i] !== 1'b1) begin bad++; $display("FAIL lanes_ready[%0d]: got %b want 1", i, x_in_ready[i]); end
      step();
      x_in_valid[i] = 1'b0;
      lat = 0;
      while (x_out_valid[i] !== 1'b1 && lat < 40) begin
        step();
        lat++;
      end
      if (x_out_valid[i] !== 1'b1) lat = -1;
      total++; if (lat != lat_exp[i]) begin bad++; $display("FAIL lanes_latency[%0d]: got %0d want %0d", i, lat, lat_exp[i]); end
      total++; if (x_out_data[i] !== SUB_A) begin bad++; $display("FAIL lanes_data[%0d]: got %h want %h", i, x_out_data[i], SUB_A); end
      x_out_ready = 1'b1;
      step();
      x_out_ready = 1'b0;
      total++; if (x_out_valid[i] !== 1'b0) begin bad++; $display("FAIL lanes_retire[%0d]: got %b want 0", i, x_out_valid[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) x_in_valid[i] = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    test_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
